// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the program-counter generator
package pc_pkg;
  typedef enum logic {BOOT, RUN} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_TRAP} rd_kind_t;
  localparam logic [63:0] DEF_RESET_VEC = 64'h8000_0000;
  localparam int DEF_INST_BYTES = 4;
endpackage

// File: rtl/pc_hist_shift.sv
// pc_hist_shift: shift register of accepted PCs with per-entry valid bits, entry 0 newest
module pc_hist_shift #(
  parameter int XLEN = 64,
  parameter int HIST_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic [XLEN-1:0]            din,
  output logic [HIST_DEPTH*XLEN-1:0] hist,
  output logic [HIST_DEPTH-1:0]      hist_valid
);
  logic [XLEN-1:0] hist_q [HIST_DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
      hist_valid <= '0;
    end else if (shift_en) begin
      hist_q[0] <= din;
      hist_valid[0] <= 1'b1;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        hist_q[i] <= hist_q[i-1];
        hist_valid[i] <= hist_valid[i-1];
      end
    end
  for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_flat
    assign hist[g*XLEN +: XLEN] = hist_q[g];
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with prioritised redirects, stall-time redirect buffering and PC history
module pc_gen
  import pc_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_VEC  = DEF_RESET_VEC,
  parameter int          INST_BYTES = DEF_INST_BYTES,
  parameter int          HIST_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       br_valid,
  input  logic [XLEN-1:0]            br_pc,
  input  logic                       trap_valid,
  input  logic [XLEN-1:0]            trap_pc,
  output logic                       req_valid,
  output logic [XLEN-1:0]            req_pc,
  input  logic                       req_ready,
  output logic [HIST_DEPTH*XLEN-1:0] pc_hist,
  output logic [HIST_DEPTH-1:0]      hist_valid,
  output logic                       misalign
);
  localparam int LSB = $clog2(INST_BYTES);
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);
  state_t state_q, state_d;
  rd_kind_t pend_q, pend_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt;
  logic redir, accept, misalign_d;
  assign req_valid = state_q == RUN && !stall;
  assign req_pc = pc_q;
  assign accept = req_valid && req_ready;
  assign redir = trap_valid || br_valid || pend_q != RD_NONE;
  assign tgt = trap_valid ? trap_pc : br_valid ? br_pc : pend_pc_q;
  always_comb begin
    state_d = RUN;
    pc_d = pc_q;
    pend_d = pend_q;
    pend_pc_d = pend_pc_q;
    misalign_d = 1'b0;
    if (stall) begin
      if (trap_valid) begin
        pend_d = RD_TRAP;
        pend_pc_d = trap_pc;
      end else if (br_valid && pend_q != RD_TRAP) begin
        pend_d = RD_BR;
        pend_pc_d = br_pc;
      end
    end else if (redir) begin
      pc_d = tgt;
      pend_d = RD_NONE;
      misalign_d = |tgt[LSB-1:0];
    end else if (accept) begin
      pc_d = pc_q + XLEN'(INST_BYTES);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RST_PC;
      pend_q <= RD_NONE;
      pend_pc_q <= '0;
      misalign <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      pend_pc_q <= pend_pc_d;
      misalign <= misalign_d;
    end
  pc_hist_shift #(.XLEN(XLEN), .HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk(clk),
    .rst(rst),
    .shift_en(accept),
    .din(req_pc),
    .hist(pc_hist),
    .hist_valid(hist_valid)
  );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen
module tb_pc_gen;
  logic clk = 0, rst = 1, stall = 0, br_valid = 0, trap_valid = 0, req_ready = 0;
  logic [63:0] br_pc = '0, trap_pc = '0, req_pc;
  logic req_valid, misalign;
  logic [127:0] pc_hist;
  logic [1:0] hist_valid;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_q[$];
  string tag_q[$];

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_valid(br_valid), .br_pc(br_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .pc_hist(pc_hist), .hist_valid(hist_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [63:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    tick; tick;
    settle;
    push("rst_valid", 0); pop(64'(req_valid));
    push("rst_pc", 64'h8000_0000); pop(req_pc);
    push("rst_hv", 0); pop(64'(hist_valid));
    push("rst_hist0", 0); pop(pc_hist[63:0]);
    push("rst_mis", 0); pop(64'(misalign));
    rst = 0; req_ready = 1; settle;
    push("boot_valid", 0); pop(64'(req_valid));
    tick;
    push("seq0_valid", 1); pop(64'(req_valid));
    push("seq0_pc", 64'h8000_0000); pop(req_pc);
    tick;
    push("seq1_pc", 64'h8000_0004); pop(req_pc);
    tick;
    push("seq2_pc", 64'h8000_0008); pop(req_pc);
    push("seq_hist0", 64'h8000_0004); pop(pc_hist[63:0]);
    push("seq_hist1", 64'h8000_0000); pop(pc_hist[127:64]);
    push("seq_hv", 3); pop(64'(hist_valid));

    rst = 1; req_ready = 0; tick;
    rst = 0; settle;
    push("rst2_boot", 0); pop(64'(req_valid));
    for (int i = 0; i < 3; i++) begin
      tick;
      push("hold_pc", 64'h8000_0000); pop(req_pc);
      push("hold_valid", 1); pop(64'(req_valid));
      push("hold_hv", 0); pop(64'(hist_valid));
    end

    br_valid = 1; br_pc = 64'h8000_1000; trap_valid = 1; trap_pc = 64'h8000_0100; req_ready = 1;
    tick;
    br_valid = 0; trap_valid = 0; settle;
    push("prio_pc", 64'h8000_0100); pop(req_pc);
    push("prio_hist0", 64'h8000_0000); pop(pc_hist[63:0]);
    push("prio_hv", 1); pop(64'(hist_valid));
    push("prio_mis", 0); pop(64'(misalign));

    stall = 1; br_valid = 1; br_pc = 64'h2000; settle;
    push("stall_valid0", 0); pop(64'(req_valid));
    tick;
    br_valid = 0; trap_valid = 1; trap_pc = 64'h3000; settle;
    push("stall_valid1", 0); pop(64'(req_valid));
    tick;
    trap_valid = 0; br_valid = 1; br_pc = 64'h4000; settle;
    push("stall_valid2", 0); pop(64'(req_valid));
    push("stall_pc", 64'h8000_0100); pop(req_pc);
    push("stall_hv", 1); pop(64'(hist_valid));
    tick;
    br_valid = 0; stall = 0; settle;
    push("unstall_valid", 1); pop(64'(req_valid));
    tick;
    push("pend_pc", 64'h3000); pop(req_pc);
    push("pend_hist0", 64'h8000_0100); pop(pc_hist[63:0]);
    push("pend_hv", 3); pop(64'(hist_valid));

    req_ready = 0; br_valid = 1; br_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick;
    br_valid = 0; settle;
    push("top_pc", 64'hFFFF_FFFF_FFFF_FFFC); pop(req_pc);
    req_ready = 1; tick;
    req_ready = 0; settle;
    push("wrap_pc", 0); pop(req_pc);
    push("wrap_mis", 0); pop(64'(misalign));
    br_valid = 1; br_pc = 64'h8000_0002; tick;
    br_valid = 0; settle;
    push("mis_pulse", 1); pop(64'(misalign));
    push("mis_pc", 64'h8000_0002); pop(req_pc);
    tick;
    push("mis_clear", 0); pop(64'(misalign));
    push("mis_pc_hold", 64'h8000_0002); pop(req_pc);

    stall = 1; trap_valid = 1; trap_pc = 64'h500; tick;
    trap_valid = 0; rst = 1; tick;
    rst = 0; stall = 0; settle;
    push("rst3_boot", 0); pop(64'(req_valid));
    push("rst3_hv", 0); pop(64'(hist_valid));
    tick;
    push("rst3_pc", 64'h8000_0000); pop(req_pc);
    push("rst3_valid", 1); pop(64'(req_valid));
    tick;
    push("rst3_nopend", 64'h8000_0000); pop(req_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
